// File: rtl/agex_sequencer.sv
// Control sequencer for the agex datapath: walks ADD/OR/SHR/JMP through address generation, memory wait and execute.
// Optional MEMWAIT timeout is compiled in when AGEX_SEQ_TIMEOUT_EN is defined.
module agex_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inst_valid,
    input  logic [2:0] inst_op,
    input  logic [7:0] modrm,
    input  logic       mem_ready,
    output logic       inst_ack,
    output logic       busy,
    output logic       seq_err,
    output logic       mem_rd,
    output logic       gate_addr_gen,
    output logic       gate_alu,
    output logic [2:0] sr1_select,
    output logic [2:0] sr2_select,
    output logic [2:0] dr_select,
    output logic       dr_we,
    output logic       en_alu_shf,
    output logic       en_eip,
    output logic       sr1_mux_s,
    output logic [1:0] sr2_mux_s,
    output logic [1:0] aluk,
    output logic [1:0] alu_shf_mux_s,
    output logic [1:0] eip_adder_mux_s,
    output logic [1:0] eip_in_mux_s
);

    typedef enum logic [2:0] {IDLE, AGEN, MEMWAIT, EXEC, DONE} state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_JREL = 3'b011;
    localparam logic [2:0] OP_JABS = 3'b100;

    state_t     state, state_nxt;
    logic [2:0] op_q;
    logic [7:0] modrm_q;
    logic       mod_reg_q, mod_reg_in;
    logic [2:0] reg_q, rm_q;
    logic       timeout;

    assign mod_reg_q  = (modrm_q[7:6] == 2'b11);
    assign mod_reg_in = (modrm[7:6] == 2'b11);
    assign reg_q      = modrm_q[5:3];
    assign rm_q       = modrm_q[2:0];

    // Illegal opcodes and SHR with a memory destination are rejected as errors.
    function automatic logic op_bad(input logic [2:0] op, input logic is_reg);
        return (op > OP_JABS) || (op == OP_SHR && !is_reg);
    endfunction

`ifdef AGEX_SEQ_TIMEOUT_EN
    logic [3:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            wait_cnt <= 4'd0;
        else if (state == AGEN)
            wait_cnt <= 4'd0;
        else if (state == MEMWAIT)
            wait_cnt <= wait_cnt + 4'd1;
    end

    // Fires in the 16th consecutive MEMWAIT cycle without data.
    assign timeout = (state == MEMWAIT) && !mem_ready && (wait_cnt == 4'hF);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= 3'd0;
            modrm_q <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && inst_valid) begin
                op_q    <= inst_op;
                modrm_q <= modrm;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        inst_ack        = 1'b0;
        busy            = (state != IDLE);
        seq_err         = 1'b0;
        mem_rd          = 1'b0;
        gate_addr_gen   = 1'b0;
        gate_alu        = 1'b0;
        sr1_select      = 3'd0;
        sr2_select      = 3'd0;
        dr_select       = 3'd0;
        dr_we           = 1'b0;
        en_alu_shf      = 1'b0;
        en_eip          = 1'b0;
        sr1_mux_s       = 1'b0;
        sr2_mux_s       = 2'b00;
        aluk            = 2'b00;
        alu_shf_mux_s   = 2'b00;
        eip_adder_mux_s = 2'b00;
        eip_in_mux_s    = 2'b00;

        case (state)
            IDLE: begin
                if (inst_valid) begin
                    if (op_bad(inst_op, mod_reg_in))
                        state_nxt = DONE;
                    else if (!mod_reg_in && inst_op != OP_SHR && inst_op != OP_JREL)
                        state_nxt = AGEN;
                    else
                        state_nxt = EXEC;
                end
            end
            AGEN: begin
                sr1_select    = rm_q;
                gate_addr_gen = 1'b1;
                mem_rd        = 1'b1;
                state_nxt     = MEMWAIT;
            end
            MEMWAIT: begin
                if (mem_ready) begin
                    if (op_q == OP_JABS) begin
                        eip_in_mux_s = 2'b11;
                        en_eip       = 1'b1;
                        state_nxt    = DONE;
                    end else begin
                        alu_shf_mux_s = 2'b11;
                        en_alu_shf    = 1'b1;
                        state_nxt     = EXEC;
                    end
                end else if (timeout) begin
                    seq_err   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            EXEC: begin
                state_nxt = DONE;
                case (op_q)
                    OP_ADD, OP_OR: begin
                        sr1_select = reg_q;
                        sr2_select = mod_reg_q ? rm_q : reg_q;
                        sr1_mux_s  = !mod_reg_q;
                        aluk       = (op_q == OP_OR) ? 2'b01 : 2'b00;
                        gate_alu   = 1'b1;
                        dr_we      = 1'b1;
                        dr_select  = reg_q;
                    end
                    OP_SHR: begin
                        sr1_select = rm_q;
                        sr2_mux_s  = 2'b10;
                        aluk       = 2'b11;
                        gate_alu   = 1'b1;
                        dr_we      = 1'b1;
                        dr_select  = rm_q;
                    end
                    OP_JREL: begin
                        eip_adder_mux_s = 2'b11;
                        eip_in_mux_s    = 2'b00;
                        en_eip          = 1'b1;
                    end
                    OP_JABS: begin
                        sr1_select   = rm_q;
                        eip_in_mux_s = 2'b01;
                        en_eip       = 1'b1;
                    end
                    default: ;
                endcase
            end
            DONE: begin
                inst_ack  = 1'b1;
                seq_err   = op_bad(op_q, mod_reg_q);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_agex_sequencer.sv
// Directed bench for agex_sequencer; define AGEX_SEQ_TIMEOUT_EN to exercise the MEMWAIT timeout.
module tb_agex_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inst_valid = 1'b0;
    logic [2:0] inst_op = 3'd0;
    logic [7:0] modrm = 8'd0;
    logic       mem_ready = 1'b0;

    logic       inst_ack, busy, seq_err, mem_rd, gate_addr_gen, gate_alu;
    logic [2:0] sr1_select, sr2_select, dr_select;
    logic       dr_we, en_alu_shf, en_eip, sr1_mux_s;
    logic [1:0] sr2_mux_s, aluk, alu_shf_mux_s, eip_adder_mux_s, eip_in_mux_s;

    int errors = 0;
    int checks = 0;
    logic both_gates_seen = 1'b0;

    agex_sequencer dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_op(inst_op),
        .modrm(modrm), .mem_ready(mem_ready), .inst_ack(inst_ack), .busy(busy),
        .seq_err(seq_err), .mem_rd(mem_rd), .gate_addr_gen(gate_addr_gen),
        .gate_alu(gate_alu), .sr1_select(sr1_select), .sr2_select(sr2_select),
        .dr_select(dr_select), .dr_we(dr_we), .en_alu_shf(en_alu_shf),
        .en_eip(en_eip), .sr1_mux_s(sr1_mux_s), .sr2_mux_s(sr2_mux_s), .aluk(aluk),
        .alu_shf_mux_s(alu_shf_mux_s), .eip_adder_mux_s(eip_adder_mux_s),
        .eip_in_mux_s(eip_in_mux_s)
    );

    logic [29:0] all_out;
    assign all_out = {inst_ack, busy, seq_err, mem_rd, gate_addr_gen, gate_alu,
                      sr1_select, sr2_select, dr_select, dr_we, en_alu_shf, en_eip,
                      sr1_mux_s, sr2_mux_s, aluk, alu_shf_mux_s, eip_adder_mux_s,
                      eip_in_mux_s};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #2;
        if (gate_alu && gate_addr_gen) both_gates_seen = 1'b1;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(); cyc(); #1;
        checks++;
        if (all_out !== 30'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        rst_n = 1'b1;
        cyc(); #1;
        checks++;
        if (all_out !== 30'd0) begin errors++; $display("FAIL idle_outputs: got %h want 0", all_out); end
    endtask

    task automatic test_reg_alu();
        inst_valid = 1'b1; inst_op = 3'b000; modrm = 8'hC1;
        cyc(); inst_valid = 1'b0; #1;
        checks++;
        if ({busy, sr1_select, sr2_select, dr_select, dr_we, aluk, gate_alu, sr1_mux_s, sr2_mux_s, gate_addr_gen, mem_rd}
            !== {1'b1, 3'd0, 3'd1, 3'd0, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0}) begin
            errors++; $display("FAIL add_reg_exec: got sr1=%0d sr2=%0d dr=%0d we=%b aluk=%b", sr1_select, sr2_select, dr_select, dr_we, aluk);
        end
        cyc(); #1;
        checks++;
        if ({inst_ack, seq_err, dr_we, gate_alu} !== 4'b1000) begin
            errors++; $display("FAIL add_reg_ack: got %b want 1000", {inst_ack, seq_err, dr_we, gate_alu});
        end
        cyc(); #1;
        checks++;
        if (all_out !== 30'd0) begin errors++; $display("FAIL add_reg_idle: got %h want 0", all_out); end

        inst_valid = 1'b1; inst_op = 3'b001; modrm = 8'hD8;
        cyc(); inst_valid = 1'b0; #1;
        checks++;
        if ({sr1_select, sr2_select, dr_select, dr_we, aluk, gate_alu, sr1_mux_s, sr2_mux_s}
            !== {3'd3, 3'd0, 3'd3, 1'b1, 2'b01, 1'b1, 1'b0, 2'b00}) begin
            errors++; $display("FAIL or_reg_exec: got sr1=%0d sr2=%0d dr=%0d aluk=%b", sr1_select, sr2_select, dr_select, aluk);
        end
        cyc(); #1;
        checks++;
        if (inst_ack !== 1'b1) begin errors++; $display("FAIL or_reg_ack: got %b want 1", inst_ack); end
        cyc();
    endtask

    task automatic test_mem_alu();
        inst_valid = 1'b1; inst_op = 3'b001; modrm = 8'h43;
        cyc(); inst_valid = 1'b0; #1;
        checks++;
        if ({gate_addr_gen, mem_rd, sr1_select, gate_alu, en_alu_shf} !== {1'b1, 1'b1, 3'd3, 1'b0, 1'b0}) begin
            errors++; $display("FAIL or_mem_agen: got gag=%b rd=%b sr1=%0d", gate_addr_gen, mem_rd, sr1_select);
        end
        cyc(); #1;
        checks++;
        if ({busy, gate_addr_gen, mem_rd, en_alu_shf} !== 4'b1000) begin
            errors++; $display("FAIL or_mem_wait: got %b want 1000", {busy, gate_addr_gen, mem_rd, en_alu_shf});
        end
        cyc();
        cyc(); mem_ready = 1'b1; #1;
        checks++;
        if ({en_alu_shf, alu_shf_mux_s, gate_alu, dr_we} !== {1'b1, 2'b11, 1'b0, 1'b0}) begin
            errors++; $display("FAIL or_mem_ready: got en=%b mux=%b", en_alu_shf, alu_shf_mux_s);
        end
        cyc(); mem_ready = 1'b0; #1;
        checks++;
        if ({sr1_select, sr2_select, dr_select, sr1_mux_s, sr2_mux_s, aluk, gate_alu, dr_we, en_alu_shf}
            !== {3'd0, 3'd0, 3'd0, 1'b1, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL or_mem_exec: got sr1mux=%b aluk=%b we=%b", sr1_mux_s, aluk, dr_we);
        end
        cyc(); #1;
        checks++;
        if (inst_ack !== 1'b1) begin errors++; $display("FAIL or_mem_ack: got %b want 1", inst_ack); end
        cyc(); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL or_mem_idle: got %b want 0", busy); end
    endtask

    task automatic test_jmp();
        inst_valid = 1'b1; inst_op = 3'b011; modrm = 8'h00;
        cyc(); inst_valid = 1'b0; #1;
        checks++;
        if ({en_eip, eip_adder_mux_s, eip_in_mux_s, dr_we, gate_alu, mem_rd} !== {1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL jrel_exec: got en=%b add=%b in=%b", en_eip, eip_adder_mux_s, eip_in_mux_s);
        end
        cyc(); #1;
        checks++;
        if (inst_ack !== 1'b1) begin errors++; $display("FAIL jrel_ack: got %b want 1", inst_ack); end
        cyc();

        inst_valid = 1'b1; inst_op = 3'b100; modrm = 8'h06;
        cyc(); inst_valid = 1'b0; #1;
        checks++;
        if ({gate_addr_gen, mem_rd, sr1_select} !== {1'b1, 1'b1, 3'd6}) begin
            errors++; $display("FAIL jabs_agen: got gag=%b sr1=%0d", gate_addr_gen, sr1_select);
        end
        cyc(); #1;
        checks++;
        if (en_eip !== 1'b0) begin errors++; $display("FAIL jabs_wait: got en_eip=%b want 0", en_eip); end
        cyc(); mem_ready = 1'b1; #1;
        checks++;
        if ({en_eip, eip_in_mux_s, en_alu_shf, inst_ack} !== {1'b1, 2'b11, 1'b0, 1'b0}) begin
            errors++; $display("FAIL jabs_ready: got en=%b in=%b", en_eip, eip_in_mux_s);
        end
        cyc(); mem_ready = 1'b0; #1;
        checks++;
        if ({inst_ack, en_eip} !== 2'b10) begin errors++; $display("FAIL jabs_ack: got %b want 10", {inst_ack, en_eip}); end
        cyc();

        inst_valid = 1'b1; inst_op = 3'b100; modrm = 8'hC5;
        cyc(); inst_valid = 1'b0; #1;
        checks++;
        if ({sr1_select, eip_in_mux_s, en_eip, eip_adder_mux_s} !== {3'd5, 2'b01, 1'b1, 2'b00}) begin
            errors++; $display("FAIL jabs_reg_exec: got sr1=%0d in=%b en=%b", sr1_select, eip_in_mux_s, en_eip);
        end
        cyc(); #1;
        checks++;
        if (inst_ack !== 1'b1) begin errors++; $display("FAIL jabs_reg_ack: got %b want 1", inst_ack); end
        cyc();
    endtask

    task automatic test_shr();
        inst_valid = 1'b1; inst_op = 3'b010; modrm = 8'hC2;
        cyc(); inst_valid = 1'b0; #1;
        checks++;
        if ({sr1_select, sr2_mux_s, aluk, gate_alu, dr_we, dr_select, sr1_mux_s}
            !== {3'd2, 2'b10, 2'b11, 1'b1, 1'b1, 3'd2, 1'b0}) begin
            errors++; $display("FAIL shr_exec: got sr1=%0d sr2mux=%b aluk=%b dr=%0d", sr1_select, sr2_mux_s, aluk, dr_select);
        end
        cyc(); #1;
        checks++;
        if ({inst_ack, seq_err} !== 2'b10) begin errors++; $display("FAIL shr_ack: got %b want 10", {inst_ack, seq_err}); end
        cyc();
    endtask

    task automatic test_illegal();
        logic [2:0] ops [2];
        logic [7:0] mrm [2];
        ops[0] = 3'b111; mrm[0] = 8'hC0;
        ops[1] = 3'b010; mrm[1] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            inst_valid = 1'b1; inst_op = ops[i]; modrm = mrm[i];
            cyc(); inst_valid = 1'b0; #1;
            checks++;
            if ({seq_err, inst_ack, busy, dr_we, en_eip, gate_alu, gate_addr_gen} !== 7'b1110000) begin
                errors++; $display("FAIL illegal_%0d_done: got %b want 1110000", i, {seq_err, inst_ack, busy, dr_we, en_eip, gate_alu, gate_addr_gen});
            end
            cyc(); #1;
            checks++;
            if (all_out !== 30'd0) begin errors++; $display("FAIL illegal_%0d_idle: got %h want 0", i, all_out); end
        end
    endtask

    task automatic test_reset_midop();
        inst_valid = 1'b1; inst_op = 3'b000; modrm = 8'h00;
        cyc(); inst_valid = 1'b0;
        cyc(); rst_n = 1'b0; #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy: got %b want 1", busy); end
        cyc(); rst_n = 1'b1; mem_ready = 1'b1; #1;
        checks++;
        if (all_out !== 30'd0) begin errors++; $display("FAIL midop_reset: got %h want 0", all_out); end
        cyc(); #1;
        checks++;
        if (all_out !== 30'd0) begin errors++; $display("FAIL midop_after: got %h want 0", all_out); end
        mem_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0] ack_v, busy_v, eip_v, we_v;
        inst_valid = 1'b1; inst_op = 3'b000; modrm = 8'hC1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i == 0) inst_op = 3'b011;
            if (i == 5) inst_valid = 1'b0;
            #1;
            ack_v[i] = inst_ack; busy_v[i] = busy; eip_v[i] = en_eip; we_v[i] = dr_we;
        end
        checks++;
        if (busy_v !== 6'b011011) begin errors++; $display("FAIL b2b_busy: got %b want 011011", busy_v); end
        checks++;
        if (ack_v !== 6'b010010) begin errors++; $display("FAIL b2b_ack: got %b want 010010", ack_v); end
        checks++;
        if ({eip_v, we_v} !== {6'b001000, 6'b000001}) begin
            errors++; $display("FAIL b2b_enables: got eip=%b we=%b want 001000 000001", eip_v, we_v);
        end
        cyc(); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        logic early;
        early = 1'b0;
        inst_valid = 1'b1; inst_op = 3'b000; modrm = 8'h00;
        cyc(); inst_valid = 1'b0;
`ifdef AGEX_SEQ_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            cyc(); #1;
            if (k < 16) early = early | seq_err | inst_ack;
        end
        checks++;
        if ({seq_err, inst_ack} !== 2'b10) begin errors++; $display("FAIL timeout_pulse: got %b want 10", {seq_err, inst_ack}); end
        checks++;
        if (early !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", early); end
        cyc(); #1;
        checks++;
        if ({busy, inst_ack, seq_err} !== 3'b000) begin errors++; $display("FAIL timeout_idle: got %b want 000", {busy, inst_ack, seq_err}); end
`else
        for (int k = 1; k <= 20; k++) begin
            cyc(); #1;
            early = early | seq_err | inst_ack;
        end
        checks++;
        if ({busy, early} !== 2'b10) begin errors++; $display("FAIL wait_forever: got %b want 10", {busy, early}); end
        rst_n = 1'b0;
        cyc(); rst_n = 1'b1;
        cyc(); #1;
        checks++;
        if (all_out !== 30'd0) begin errors++; $display("FAIL wait_reset: got %h want 0", all_out); end
`endif
    endtask

    task automatic test_gates();
        checks++;
        if (both_gates_seen !== 1'b0) begin errors++; $display("FAIL gate_exclusive: got %b want 0", both_gates_seen); end
    endtask

    initial begin
        test_reset();
        test_reg_alu();
        test_mem_alu();
        test_jmp();
        test_shr();
        test_illegal();
        test_reset_midop();
        test_back_to_back();
        test_timeout();
        test_gates();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
